// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Arbitrates the single shared memory port of the pipelined MIPS core between
// instruction fetch (IF) and load/store (MEM). Requests are serialised onto one
// ready-handshaked bus. Per-requester stall outputs freeze the pipeline until
// each access completes. IF flush squashes an in-flight fetch.
//
// Handshake: a requester holds its level request (if_req, mem_rd/mem_wr) and
// its address/data stable until its stall output is low. That cycle is the
// completion cycle, and the matching rdata output is valid in it. On the bus
// side, bus_req is held high with stable bus_addr/bus_we/bus_wdata until the
// slave returns bus_ready=1, which ends the transaction in that cycle.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a BUSY wait counter aborts a transaction after
//   TIMEOUT_CYCLES cycles without bus_ready, and raises bus_err/bus_err_src.
//   When undefined, the arbiter waits forever and bus_err/bus_err_src are 0.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush  fetch request, address, squash
//   if_rdata/if_stall        fetch data, fetch stall
//   mem_rd/mem_wr            load/store request (both high is treated as store)
//   mem_addr/mem_wdata       data address, store data
//   mem_rdata/mem_stall      load data, MEM stall
//   bus_req/bus_we           bus transaction active, write strobe (registered)
//   bus_addr/bus_wdata       bus address, store data (registered)
//   bus_rdata/bus_ready      bus read data, transaction complete
//   bus_err/bus_err_src      abort pulse, aborted source (0 = IF, 1 = MEM)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err,
    output logic        bus_err_src
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic drop;       // current fetch was squashed, its data must not be used
    logic last_mem;   // last completed access was MEM: give IF the next turn
    logic mem_any;
    logic drop_now;   // squash including a flush arriving this very cycle
    logic abort;      // timeout abort in this cycle
    logic done;       // current BUSY transaction ends this cycle

    assign mem_any  = mem_rd | mem_wr;
    assign drop_now = drop | ((state == IF_BUSY) & if_flush);
    assign done     = bus_ready | abort;

    // -------------------------------------------------------------------------
    // Optional bus timeout
    // -------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // The counter holds the number of earlier wait cycles, so the abort fires
    // in the wait cycle that brings the total to TIMEOUT_CYCLES.
    assign abort = (state != IDLE) & ~bus_ready &
                   (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (!bus_ready) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign bus_err     = abort;
    assign bus_err_src = abort & (state == MEM_BUSY);
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign abort          = 1'b0;
    assign bus_err        = 1'b0;
    assign bus_err_src    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                // MEM normally wins; right after a MEM completion a waiting
                // fetch gets one turn. A flush in IDLE withholds the IF grant.
                if (mem_any && !(if_req && last_mem && !if_flush)) begin
                    state_next = MEM_BUSY;
                end else if (if_req && !if_flush) begin
                    state_next = IF_BUSY;
                end
            end
            IF_BUSY, MEM_BUSY: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered bus outputs: captured only when a BUSY state is entered,
    // then held stable for the whole transaction.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            bus_req <= (state_next != IDLE);
            if (state == IDLE && state_next == MEM_BUSY) begin
                bus_addr  <= mem_addr;
                bus_we    <= mem_wr;      // rd+wr together resolves to a write
                bus_wdata <= mem_wdata;
            end else if (state == IDLE && state_next == IF_BUSY) begin
                bus_addr  <= if_addr;
                bus_we    <= 1'b0;
                bus_wdata <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drop and fairness flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop     <= 1'b0;
            last_mem <= 1'b0;
        end else begin
            drop <= (state == IF_BUSY && state_next == IF_BUSY) ? drop_now : 1'b0;
            if (state == MEM_BUSY && done) begin
                last_mem <= 1'b1;
            end else if (state == IF_BUSY && done) begin
                last_mem <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Requester-side outputs (combinational from bus_ready/bus_rdata)
    // -------------------------------------------------------------------------
    assign if_stall  = if_req & ~((state == IF_BUSY) & done & ~drop_now);
    assign mem_stall = mem_any & ~((state == MEM_BUSY) & done);

    assign if_rdata  = ((state == IF_BUSY) & bus_ready & ~drop_now) ? bus_rdata : '0;
    assign mem_rdata = ((state == MEM_BUSY) & bus_ready) ? bus_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A cycle-by-cycle trace table holds the
// inputs applied in each cycle and the outputs expected in that cycle; the
// asynchronous reset (and the timeout, when MEM_TIMEOUT_EN is defined) are
// exercised by hand-written sequences afterwards.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] IA  = 32'h0040_0000;
    localparam logic [31:0] IA4 = 32'h0040_0004;
    localparam logic [31:0] IB  = 32'h0040_0100;
    localparam logic [31:0] IB4 = 32'h0040_0104;
    localparam logic [31:0] MA  = 32'h1001_0000;
    localparam logic [31:0] MA4 = 32'h1001_0004;
    localparam logic [31:0] MA8 = 32'h1001_0008;
    localparam logic [31:0] D   = 32'hDEAD_BEEF;
    localparam logic [31:0] R   = 32'h8C02_0004;
    localparam logic [31:0] R2  = 32'h3C01_1001;
    localparam logic [31:0] CF  = 32'hCAFE_F00D;
    localparam logic [31:0] PA  = 32'h55AA_55AA;
    localparam int          NV  = 25;

    // ---------------------------------------------------------------- clock/reset
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        if_req, if_flush, mem_rd, mem_wr, bus_ready;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_stall, mem_stall, bus_req, bus_we, bus_err, bus_err_src;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_stall  (mem_stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready),
        .bus_err    (bus_err),
        .bus_err_src(bus_err_src)
    );

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        ir, fl, mr, mw, rdy;
        logic [31:0] ia, ma, rd;
        logic        e_is, e_ms, e_br, e_bw;
        logic [31:0] e_ird, e_mrd, e_ba, e_bwd;
    } vec_t;

    vec_t tbl[NV];

    function automatic vec_t mk(
        input logic ir, input logic fl, input logic [31:0] ia,
        input logic mr, input logic mw, input logic [31:0] ma,
        input logic rdy, input logic [31:0] rd,
        input logic e_is, input logic [31:0] e_ird,
        input logic e_ms, input logic [31:0] e_mrd,
        input logic e_br, input logic e_bw,
        input logic [31:0] e_ba, input logic [31:0] e_bwd);
        vec_t v;
        v.ir = ir; v.fl = fl; v.ia = ia; v.mr = mr; v.mw = mw; v.ma = ma;
        v.rdy = rdy; v.rd = rd;
        v.e_is = e_is; v.e_ird = e_ird; v.e_ms = e_ms; v.e_mrd = e_mrd;
        v.e_br = e_br; v.e_bw = e_bw; v.e_ba = e_ba; v.e_bwd = e_bwd;
        return v;
    endfunction

    // ---------------------------------------------------------------- checker
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver
    task automatic drive(input vec_t v);
        if_req    = v.ir;
        if_flush  = v.fl;
        if_addr   = v.ia;
        mem_rd    = v.mr;
        mem_wr    = v.mw;
        mem_addr  = v.ma;
        bus_ready = v.rdy;
        bus_rdata = v.rd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        check($sformatf("row%0d if_stall", i),  32'(if_stall),  32'(v.e_is));
        check($sformatf("row%0d if_rdata", i),  if_rdata,       v.e_ird);
        check($sformatf("row%0d mem_stall", i), 32'(mem_stall), 32'(v.e_ms));
        check($sformatf("row%0d mem_rdata", i), mem_rdata,      v.e_mrd);
        check($sformatf("row%0d bus_req", i),   32'(bus_req),   32'(v.e_br));
        check($sformatf("row%0d bus_we", i),    32'(bus_we),    32'(v.e_bw));
        check($sformatf("row%0d bus_addr", i),  bus_addr,       v.e_ba);
        check($sformatf("row%0d bus_wdata", i), bus_wdata,      v.e_bwd);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- test
    initial begin
        //             ir fl ia   mr mw ma  rdy rd | is ird ms mrd br bw ba  bwd
        // single fetch, ready in the 3rd busy cycle
        tbl[0]  = mk(1, 0, IA,  0, 0, 0,   0, 0,  1, 0,  0, 0,  0, 0, 0,   0);
        tbl[1]  = mk(1, 0, IA,  0, 0, 0,   0, 0,  1, 0,  0, 0,  1, 0, IA,  0);
        tbl[2]  = mk(1, 0, IA,  0, 0, 0,   0, 0,  1, 0,  0, 0,  1, 0, IA,  0);
        tbl[3]  = mk(1, 0, IA,  0, 0, 0,   1, R,  0, R,  0, 0,  1, 0, IA,  0);
        tbl[4]  = mk(0, 0, IA,  0, 0, 0,   0, 0,  0, 0,  0, 0,  0, 0, IA,  0);
        // contention: MEM write first, then IF (fairness), then MEM read
        tbl[5]  = mk(1, 0, IA,  0, 1, MA,  0, 0,  1, 0,  1, 0,  0, 0, IA,  0);
        tbl[6]  = mk(1, 0, IA,  0, 1, MA,  1, 0,  1, 0,  0, 0,  1, 1, MA,  D);
        tbl[7]  = mk(1, 0, IA,  1, 0, MA4, 0, 0,  1, 0,  1, 0,  0, 1, MA,  D);
        tbl[8]  = mk(1, 0, IA,  1, 0, MA4, 1, R2, 0, R2, 1, 0,  1, 0, IA,  0);
        tbl[9]  = mk(1, 0, IA4, 1, 0, MA4, 0, 0,  1, 0,  1, 0,  0, 0, IA,  0);
        tbl[10] = mk(1, 0, IA4, 1, 0, MA4, 1, CF, 1, 0,  0, CF, 1, 0, MA4, D);
        tbl[11] = mk(1, 0, IA4, 0, 0, 0,   0, 0,  1, 0,  0, 0,  0, 0, MA4, D);
        // flush mid-fetch, ready two cycles later, refetch from IB
        tbl[12] = mk(1, 1, IA4, 0, 0, 0,   0, 0,  1, 0,  0, 0,  1, 0, IA4, 0);
        tbl[13] = mk(1, 0, IB,  0, 0, 0,   0, 0,  1, 0,  0, 0,  1, 0, IA4, 0);
        tbl[14] = mk(1, 0, IB,  0, 0, 0,   1, R,  1, 0,  0, 0,  1, 0, IA4, 0);
        tbl[15] = mk(1, 0, IB,  0, 0, 0,   0, 0,  1, 0,  0, 0,  0, 0, IA4, 0);
        tbl[16] = mk(1, 0, IB,  0, 0, 0,   1, R,  0, R,  0, 0,  1, 0, IB,  0);
        // flush in IDLE blocks the grant; flush in the completion cycle drops
        tbl[17] = mk(1, 1, IB4, 0, 0, 0,   0, 0,  1, 0,  0, 0,  0, 0, IB,  0);
        tbl[18] = mk(1, 0, IB4, 0, 0, 0,   0, 0,  1, 0,  0, 0,  0, 0, IB,  0);
        tbl[19] = mk(1, 0, IB4, 0, 0, 0,   0, 0,  1, 0,  0, 0,  1, 0, IB4, 0);
        tbl[20] = mk(1, 1, IB4, 0, 0, 0,   1, R,  1, 0,  0, 0,  1, 0, IB4, 0);
        // illegal rd+wr resolves to a write; flush does not touch MEM
        tbl[21] = mk(0, 0, IB4, 1, 1, MA8, 0, 0,  0, 0,  1, 0,  0, 0, IB4, 0);
        tbl[22] = mk(0, 1, IB4, 1, 1, MA8, 0, 0,  0, 0,  1, 0,  1, 1, MA8, D);
        tbl[23] = mk(0, 0, IB4, 1, 1, MA8, 1, PA, 0, 0,  0, PA, 1, 1, MA8, D);
        tbl[24] = mk(0, 0, IB4, 0, 0, 0,   0, 0,  0, 0,  0, 0,  0, 1, MA8, D);

        // reset state
        rst_n = 1'b0;
        if_req = 0; if_flush = 0; if_addr = 0; mem_rd = 0; mem_wr = 0;
        mem_addr = 0; mem_wdata = D; bus_ready = 0; bus_rdata = 0;
        #3;
        check("reset bus_req",   32'(bus_req),  0);
        check("reset bus_addr",  bus_addr,      0);
        check("reset bus_err",   32'(bus_err),  0);
        check("reset if_stall",  32'(if_stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            check_vec(i, tbl[i]);
        end

        // asynchronous reset in the middle of a MEM transaction
        @(negedge clk);
        if_req = 0; if_flush = 0; mem_rd = 1; mem_wr = 0;
        mem_addr = 32'h1001_0010; bus_ready = 0;
        #1;
        check("arst grant bus_req", 32'(bus_req), 0);
        @(negedge clk);
        #1;
        check("arst busy bus_req", 32'(bus_req), 1);
        #2;
        rst_n = 1'b0;
        bus_ready = 1; bus_rdata = 32'h1234_5678;
        #1;
        check("arst bus_req",   32'(bus_req),   0);
        check("arst bus_addr",  bus_addr,       0);
        check("arst bus_we",    32'(bus_we),    0);
        check("arst mem_stall", 32'(mem_stall), 1);
        check("arst mem_rdata", mem_rdata,      0);
        @(negedge clk);
        rst_n = 1'b1; bus_ready = 0;
        #1;
        check("post-rst idle bus_req", 32'(bus_req), 0);
        @(negedge clk);
        bus_ready = 1; bus_rdata = 32'h0BAD_F00D;
        #1;
        check("post-rst bus_req",   32'(bus_req),   1);
        check("post-rst bus_addr",  bus_addr,       32'h1001_0010);
        check("post-rst mem_stall", 32'(mem_stall), 0);
        check("post-rst mem_rdata", mem_rdata,      32'h0BAD_F00D);
        @(negedge clk);
        mem_rd = 0; bus_ready = 0;
        #1;
        check("post-rst done bus_req", 32'(bus_req), 0);

`ifdef MEM_TIMEOUT_EN
        // MEM read never answered: abort in the 4th wait cycle
        @(negedge clk);
        mem_rd = 1; mem_addr = 32'h1001_0020; bus_rdata = 32'hFFFF_FFFF;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            #1;
            check($sformatf("tmo w%0d bus_req", w),   32'(bus_req),   1);
            check($sformatf("tmo w%0d bus_err", w),   32'(bus_err),   (w == 4) ? 1 : 0);
            check($sformatf("tmo w%0d mem_stall", w), 32'(mem_stall), (w == 4) ? 0 : 1);
        end
        check("tmo bus_err_src", 32'(bus_err_src), 1);
        check("tmo mem_rdata",   mem_rdata,        0);
        @(negedge clk);
        mem_rd = 0;
        #1;
        check("tmo release bus_req", 32'(bus_req), 0);
        check("tmo release bus_err", 32'(bus_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared memory port of the pipelined MIPS core. It accepts instruction-fetch requests from IF and load/store requests from MEM (driven by the MemRead/MemWrite bits of the packed control word). It serialises them onto one ready-handshaked memory bus and returns per-requester stall signals that freeze the pipeline until each access completes. It also honours the IF flush signal so that fetches on a squashed path are discarded.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus wait cycles before abort. Used only with `MEM_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, level; held until `if_stall`=0.
- `if_addr` in 32: fetch address.
- `if_flush` in 1: IFFlush; discards any in-flight fetch.
- `if_rdata` out 32: fetch data; valid when `if_req`=1 and `if_stall`=0.
- `if_stall` out 1: IF must hold.
- `mem_rd` in 1: load request, level.
- `mem_wr` in 1: store request, level.
- `mem_addr` in 32: data address.
- `mem_wdata` in 32: store data.
- `mem_rdata` out 32: load data; valid when `mem_stall`=0.
- `mem_stall` out 1: MEM (and upstream) must hold.
- `bus_req` out 1: bus transaction active.
- `bus_we` out 1: write strobe.
- `bus_addr` out 32: registered address.
- `bus_wdata` out 32: registered store data.
- `bus_rdata` in 32: read data; valid with `bus_ready`.
- `bus_ready` in 1: completes the current transaction.
- `bus_err` out 1: one-cycle abort pulse. Tied to 0 without `MEM_TIMEOUT_EN`.
- `bus_err_src` out 1: source of the aborted transaction; 0 = IF, 1 = MEM.

## Operation
- States: IDLE, IF_BUSY, MEM_BUSY.
- **IDLE**
  - If `mem_rd|mem_wr` is high, go to MEM_BUSY. Exception: if `if_req`=1 and `last_mem`=1, go to IF_BUSY instead (one-shot fairness after each MEM completion).
  - Else if `if_req` is high and `if_flush`=0, go to IF_BUSY.
  - On entering a BUSY state, register `bus_addr`, `bus_we` (= `mem_wr`), and `bus_wdata`.
- **Load/store conflict:** `mem_rd` and `mem_wr` together is illegal. The arbiter treats it as a write.
- **BUSY states**
  - `bus_req`=1 and all bus outputs are held stable.
  - On `bus_ready`=1, go to IDLE.
  - `last_mem` is set on MEM completion and cleared on IF completion.
- **Stalls (combinational)**
  - `if_stall` = `if_req` & ~(state==IF_BUSY & `bus_ready` & ~`drop`).
  - `mem_stall` = (`mem_rd`|`mem_wr`) & ~(state==MEM_BUSY & `bus_ready`).
- **Read data:** `if_rdata` and `mem_rdata` pass `bus_rdata` through while their completion cycle is active, and are 0 otherwise.
- **Flush**
  - `if_flush` in IF_BUSY sets `drop`. This includes the completion cycle.
  - The bus transaction still completes, but `if_stall` stays high. `drop` clears on return to IDLE, and the new fetch is issued from IDLE.
  - `if_flush` in IDLE blocks the IF grant for that cycle.
  - `if_flush` never affects MEM.
- **Reset** (asynchronous, at any time including mid-transaction):
  - state=IDLE, `drop`=0, `last_mem`=0.
  - `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0.
  - `bus_err`=0, `bus_err_src`=0, timeout counter=0.
  - Stalls follow their request inputs; `rdata` outputs are 0.
  - A bus transaction in flight is abandoned. The bus slave must tolerate `bus_req` falling.

## Timing
- **Grant latency:** request seen in IDLE at cycle N; `bus_req` high from cycle N+1.
- **Minimum access:** 2 cycles (request at N, `bus_ready` at N+1, stall low at N+1, pipeline advances at the N+1 edge).
- **Back-to-back:** one IDLE cycle between transactions. Peak throughput is one access per 2 cycles plus bus wait.
- **Bus outputs:** all registered, no combinational path from requester inputs to bus outputs.
- **Bus-to-requester paths:** `bus_ready` and `bus_rdata` reach the stall and `rdata` outputs combinationally.

## Configuration
- **`MEM_TIMEOUT_EN` defined:**
  - A counter of width clog2(`TIMEOUT_CYCLES`+1) counts BUSY cycles with `bus_ready`=0, and clears on entry to a BUSY state.
  - When it reaches `TIMEOUT_CYCLES` in a cycle without `bus_ready`, the arbiter does all of the following in that cycle:
    - asserts `bus_err`=1 and `bus_err_src`;
    - releases that requester's stall with `rdata`=0;
    - returns to IDLE on the next edge, dropping `bus_req`.
  - `bus_err` feeds the control unit's `exc` input.
- **`MEM_TIMEOUT_EN` undefined:** the arbiter waits indefinitely. `bus_err` and `bus_err_src` are constant 0 and no counter is built.

## Test plan
- **Single fetch:** `if_req`=1, `if_addr`=0x00400000, `bus_ready` at the 3rd BUSY cycle.
  - `bus_addr`=0x00400000 and `bus_we`=0.
  - `if_stall` low only in the ready cycle; `if_rdata`=`bus_rdata`=0x8C020004.
- **Contention:** `if_req`=1 and `mem_wr`=1 (addr 0x10010000, data 0xDEADBEEF) both in IDLE.
  - MEM is granted first with `bus_we`=1.
  - Then IF is granted even though `mem_rd` is asserted next, and MEM is granted after that.
- **Flush mid-fetch:** `if_flush` pulsed in IF_BUSY, `bus_ready` 2 cycles later.
  - `if_stall` remains 1 through completion.
  - The next fetch goes out to the new `if_addr`=0x00400100.
- **Async reset:** `rst_n` low mid MEM_BUSY.
  - `bus_req` goes to 0 within the same cycle, with no clock needed.
  - After release, a fresh `mem_rd` completes normally.
- **Timeout:** with `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, a MEM read with `bus_ready` never asserted.
  - `bus_err`=1 and `bus_err_src`=1 on the 4th wait cycle; `mem_stall`=0 and `mem_rdata`=0.
  - `bus_req`=0 on the next cycle.
- **Illegal request:** `mem_rd`=`mem_wr`=1 gives `bus_we`=1 (write wins).
